serial_tx: RTL and testbench

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_tx_pkg.sv | 15 +
 rtl/serial_tx_if.sv | 13 +
 rtl/serial_tx_baud_counter.sv | 30 +++
 rtl/serial_tx.sv | 111 +++++++++++
 tb/tb_serial_tx.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_tx_pkg.sv
// Shared types and default constants for the serial transmitter.
package serial_tx_pkg;

   // Frame sequencing states: idle line, start bit, payload bits, stop bit.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   localparam int DEF_DATA_W       = 8;
   localparam int DEF_CLKS_PER_BIT = 16;

endpackage

// File: rtl/serial_tx_if.sv
// Producer-side handshake for the serial transmitter: word offer and ready.
interface serial_tx_if
   import serial_tx_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
);
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;

   modport master (output tx_data, output tx_valid, input  tx_ready);
   modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/serial_tx_baud_counter.sv
// Per-bit cycle counter: counts 0..CLKS_PER_BIT-1, pulses bit_done on the last count.
module baud_counter
   import serial_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   output logic o_bit_done
);
   localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] r_count;

   // A held clear suppresses the pulse so an idle transmitter never sees a bit boundary.
   assign o_bit_done = (r_count == LAST) && !i_clear;

   // Count cycles within a bit; wrap at the boundary, hold at zero while cleared.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (i_clear || o_bit_done) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CNT_W'(1);
      end
   end
endmodule

// File: rtl/serial_tx.sv
// Serial transmitter: accepts a parallel word and sends start, LSB-first data, stop.
module serial_tx
   import serial_tx_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic        clk,
   input  logic        reset,
   serial_tx_if.slave  bus,
   output logic        tx,
   output logic        busy
);
   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

   if (DATA_W < 1 || DATA_W > 16) begin : g_bad_data_w
      $error("serial_tx: DATA_W must be in 1..16");
   end
   if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks
      $error("serial_tx: CLKS_PER_BIT must be in 2..65535");
   end

   state_t            r_state, w_state_nxt;
   logic [DATA_W-1:0] r_shift, w_shift_nxt;
   logic [IDX_W-1:0]  r_idx,   w_idx_nxt;
   logic              r_tx,    w_tx_nxt;
   logic              w_ready;
   logic              w_accept;
   logic              w_bit_done;

   assign w_ready      = (r_state == IDLE);
   assign w_accept     = bus.tx_valid && w_ready;
   assign bus.tx_ready = w_ready;
   assign busy         = ~w_ready;
   assign tx           = r_tx;

   baud_counter #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk        (clk),
      .reset      (reset),
      .i_clear    (w_ready),
      .o_bit_done (w_bit_done)
   );

   // State, shift register, bit index and line register update.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_idx   <= '0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_shift <= w_shift_nxt;
         r_idx   <= w_idx_nxt;
         r_tx    <= w_tx_nxt;
      end
   end

   // Next-state logic; the line value for the next bit is registered at each boundary.
   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_idx_nxt   = r_idx;
      w_tx_nxt    = r_tx;
      case (r_state)
         IDLE: begin
            w_idx_nxt = '0;
            w_tx_nxt  = 1'b1;
            if (w_accept) begin
               w_state_nxt = START;
               w_shift_nxt = bus.tx_data;
               w_tx_nxt    = 1'b0;
            end
         end
         START: begin
            if (w_bit_done) begin
               w_state_nxt = DATA;
               w_idx_nxt   = '0;
               w_tx_nxt    = r_shift[0];
               w_shift_nxt = r_shift >> 1;
            end
         end
         DATA: begin
            if (w_bit_done) begin
               if (r_idx == LAST_IDX) begin
                  w_state_nxt = STOP;
                  w_idx_nxt   = '0;
                  w_tx_nxt    = 1'b1;
               end else begin
                  w_idx_nxt   = r_idx + IDX_W'(1);
                  w_tx_nxt    = r_shift[0];
                  w_shift_nxt = r_shift >> 1;
               end
            end
         end
         STOP: begin
            if (w_bit_done) begin
               w_state_nxt = IDLE;
               w_tx_nxt    = 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_tx_nxt    = 1'b1;
         end
      endcase
   end
endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: default 8-bit/16-cycle instance plus a 5-bit/2-cycle instance.
module tb_serial_tx;

   logic clk = 1'b0;
   logic reset;
   logic tx_a, busy_a, tx_b, busy_b;
   int   n_cmp  = 0;
   int   n_fail = 0;

   serial_tx_if #(.DATA_W(8)) bus_a ();
   serial_tx_if #(.DATA_W(5)) bus_b ();

   serial_tx #(.DATA_W(8), .CLKS_PER_BIT(16)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a),
      .tx    (tx_a),
      .busy  (busy_a)
   );

   serial_tx #(.DATA_W(5), .CLKS_PER_BIT(2)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b),
      .tx    (tx_b),
      .busy  (busy_b)
   );

   always #5 clk = ~clk;

   // Expected line waveform, one bit per cycle, bit i = cycle i after acceptance.
   function automatic logic [255:0] frame_model(input logic [15:0] data, input int dw, input int cpb);
      logic [255:0] w;
      int b;
      w = '0;
      for (int i = 0; i < (dw + 2) * cpb; i++) begin
         b = i / cpb;
         if (b == 0)           w[i] = 1'b0;
         else if (b == dw + 1) w[i] = 1'b1;
         else                  w[i] = data[b-1];
      end
      return w;
   endfunction

   // Sample n cycles of one instance at falling edges; no judgement made here.
   task automatic capture(input bit which, input int n, output logic [255:0] wave,
                          output int rdy_hi, output int busy_bad);
      wave = '0;
      rdy_hi = 0;
      busy_bad = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (which) begin
            wave[i] = tx_b;
            if (bus_b.tx_ready !== 1'b0) rdy_hi++;
            if (busy_b !== ~bus_b.tx_ready) busy_bad++;
         end else begin
            wave[i] = tx_a;
            if (bus_a.tx_ready !== 1'b0) rdy_hi++;
            if (busy_a !== ~bus_a.tx_ready) busy_bad++;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (tx_a !== 1'b1) begin n_fail++; $display("FAIL rst_tx: got %b want 1", tx_a); end
      n_cmp++; if (bus_a.tx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", bus_a.tx_ready); end
      n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy_a); end
      n_cmp++; if (tx_b !== 1'b1) begin n_fail++; $display("FAIL rst_tx_b: got %b want 1", tx_b); end
      reset = 1'b1;
   endtask

   task automatic test_single_a5();
      logic [255:0] w;
      int rh, bb;
      bus_a.tx_data  = 8'hA5;
      bus_a.tx_valid = 1'b1;
      @(posedge clk); #1;
      bus_a.tx_valid = 1'b0;
      capture(1'b0, 160, w, rh, bb);
      n_cmp++; if (w !== frame_model(16'h00A5, 8, 16)) begin n_fail++; $display("FAIL a5_frame: got %h want %h", w, frame_model(16'h00A5, 8, 16)); end
      n_cmp++; if (rh !== 0) begin n_fail++; $display("FAIL a5_ready_during: got %0d cycles want 0", rh); end
      n_cmp++; if (bb !== 0) begin n_fail++; $display("FAIL a5_busy: got %0d bad cycles want 0", bb); end
      @(negedge clk);
      n_cmp++; if (bus_a.tx_ready !== 1'b1) begin n_fail++; $display("FAIL a5_ready_after: got %b want 1", bus_a.tx_ready); end
      n_cmp++; if (tx_a !== 1'b1) begin n_fail++; $display("FAIL a5_idle_tx: got %b want 1", tx_a); end
   endtask

   task automatic test_back_to_back();
      logic [255:0] w;
      int rh, bb;
      @(negedge clk);
      bus_a.tx_data  = 8'h00;
      bus_a.tx_valid = 1'b1;
      @(posedge clk); #1;
      bus_a.tx_data  = 8'hFF;
      capture(1'b0, 160, w, rh, bb);
      n_cmp++; if (w !== frame_model(16'h0000, 8, 16)) begin n_fail++; $display("FAIL b2b_frame0: got %h want %h", w, frame_model(16'h0000, 8, 16)); end
      n_cmp++; if (rh !== 0) begin n_fail++; $display("FAIL b2b_ready_during0: got %0d want 0", rh); end
      @(negedge clk);
      n_cmp++; if (bus_a.tx_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_gap_ready: got %b want 1", bus_a.tx_ready); end
      n_cmp++; if (tx_a !== 1'b1) begin n_fail++; $display("FAIL b2b_gap_tx: got %b want 1", tx_a); end
      @(posedge clk); #1;
      bus_a.tx_valid = 1'b0;
      capture(1'b0, 160, w, rh, bb);
      n_cmp++; if (w !== frame_model(16'h00FF, 8, 16)) begin n_fail++; $display("FAIL b2b_frame1: got %h want %h", w, frame_model(16'h00FF, 8, 16)); end
      n_cmp++; if (rh !== 0) begin n_fail++; $display("FAIL b2b_ready_during1: got %0d want 0", rh); end
      @(negedge clk);
      n_cmp++; if (bus_a.tx_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after: got %b want 1", bus_a.tx_ready); end
   endtask

   task automatic test_ignore_midframe();
      logic [255:0] w;
      int rh, bb;
      @(negedge clk);
      bus_a.tx_data  = 8'h3C;
      bus_a.tx_valid = 1'b1;
      @(posedge clk); #1;
      bus_a.tx_valid = 1'b0;
      fork
         capture(1'b0, 160, w, rh, bb);
         begin
            repeat (40) @(posedge clk);
            #1;
            bus_a.tx_data  = 8'hFF;
            bus_a.tx_valid = 1'b1;
            @(posedge clk); #1;
            bus_a.tx_valid = 1'b0;
            bus_a.tx_data  = 8'h00;
         end
      join
      n_cmp++; if (w !== frame_model(16'h003C, 8, 16)) begin n_fail++; $display("FAIL ign_frame: got %h want %h", w, frame_model(16'h003C, 8, 16)); end
      n_cmp++; if (rh !== 0) begin n_fail++; $display("FAIL ign_ready_during: got %0d want 0", rh); end
      @(negedge clk);
      n_cmp++; if (bus_a.tx_ready !== 1'b1) begin n_fail++; $display("FAIL ign_ready_after: got %b want 1", bus_a.tx_ready); end
      @(negedge clk);
      n_cmp++; if (tx_a !== 1'b1) begin n_fail++; $display("FAIL ign_no_queued_frame: got %b want 1", tx_a); end
   endtask

   task automatic test_reset_midframe();
      logic [255:0] w;
      int rh, bb;
      @(negedge clk);
      bus_a.tx_data  = 8'h00;
      bus_a.tx_valid = 1'b1;
      @(posedge clk); #1;
      bus_a.tx_valid = 1'b0;
      repeat (50) @(posedge clk);
      #1;
      n_cmp++; if (tx_a !== 1'b0) begin n_fail++; $display("FAIL mid_tx_low: got %b want 0", tx_a); end
      #2;
      reset = 1'b0;
      #1;
      n_cmp++; if (tx_a !== 1'b1) begin n_fail++; $display("FAIL mid_rst_tx: got %b want 1", tx_a); end
      n_cmp++; if (bus_a.tx_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 1", bus_a.tx_ready); end
      n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", busy_a); end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      bus_a.tx_data  = 8'h81;
      bus_a.tx_valid = 1'b1;
      @(posedge clk); #1;
      bus_a.tx_valid = 1'b0;
      capture(1'b0, 160, w, rh, bb);
      n_cmp++; if (w !== frame_model(16'h0081, 8, 16)) begin n_fail++; $display("FAIL mid_81_frame: got %h want %h", w, frame_model(16'h0081, 8, 16)); end
      @(negedge clk);
      n_cmp++; if (bus_a.tx_ready !== 1'b1) begin n_fail++; $display("FAIL mid_81_ready_after: got %b want 1", bus_a.tx_ready); end
   endtask

   task automatic test_small_frame();
      logic [255:0] w;
      logic [13:0]  want;
      int rh, bb;
      // start 00, data 1,1,0,0,1 as pairs, stop 11; bit 0 is the first cycle
      want = 14'b11110000111100;
      @(negedge clk);
      bus_b.tx_data  = 5'h13;
      bus_b.tx_valid = 1'b1;
      @(posedge clk); #1;
      bus_b.tx_valid = 1'b0;
      capture(1'b1, 14, w, rh, bb);
      n_cmp++; if (w[13:0] !== want) begin n_fail++; $display("FAIL small_wave: got %b want %b", w[13:0], want); end
      n_cmp++; if (w !== frame_model(16'h0013, 5, 2)) begin n_fail++; $display("FAIL small_model: got %h want %h", w, frame_model(16'h0013, 5, 2)); end
      n_cmp++; if (rh !== 0) begin n_fail++; $display("FAIL small_ready_during: got %0d want 0", rh); end
      n_cmp++; if (bb !== 0) begin n_fail++; $display("FAIL small_busy: got %0d bad cycles want 0", bb); end
      @(negedge clk);
      n_cmp++; if (bus_b.tx_ready !== 1'b1) begin n_fail++; $display("FAIL small_ready_after: got %b want 1", bus_b.tx_ready); end
      n_cmp++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL small_busy_after: got %b want 0", busy_b); end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset          = 1'b0;
      bus_a.tx_data  = '0;
      bus_a.tx_valid = 1'b0;
      bus_b.tx_data  = '0;
      bus_b.tx_valid = 1'b0;
      test_reset();
      test_single_a5();
      test_back_to_back();
      test_ignore_midframe();
      test_reset_midframe();
      test_small_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
